// File: rtl/loteria_pkg.sv
// Shared types and width helpers for the multi-player lottery block.
package loteria_pkg;

    typedef enum logic [1:0] {
        SORTEIO   = 2'd0,
        APOSTA    = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    // Width of a hit counter able to hold 0..num_qtd.
    function automatic int pts_w(input int num_qtd);
        return $clog2(num_qtd + 1);
    endfunction

    // Width of a prize code: 0 = nobody, i+1 = player i.
    function automatic int prm_w(input int n_jog);
        return $clog2(n_jog + 1);
    endfunction

endpackage

// File: rtl/loteria_comparador.sv
// Combinational membership test of one number against a masked register array.
module loteria_comparador #(
    parameter int NUM_W   = 4,
    parameter int NUM_QTD = 5
) (
    input  logic [NUM_W-1:0]              valor,
    input  logic [NUM_QTD-1:0][NUM_W-1:0] tabela,
    input  logic [NUM_QTD-1:0]            valido,
    output logic                          hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_QTD; i++) begin
            if (valido[i] && (tabela[i] == valor)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/loteria_multi.sv
// Parametrised lottery: load a distinct draw, take one ticket per player,
// count hits and declare the winner when the game ends.
module loteria_multi
    import loteria_pkg::*;
#(
    parameter int NUM_W       = 4,
    parameter int NUM_QTD     = 5,
    parameter int N_JOG       = 2,
    parameter int MIN_ACERTOS = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_W-1:0]                      numero,
    input  logic                                  insere,
    input  logic                                  fim,
    input  logic                                  fim_jogo,
    output logic [1:0]                            estado,
    output logic [prm_w(N_JOG)-1:0]               jogador,
    output logic [N_JOG*pts_w(NUM_QTD)-1:0]       pontos,
    output logic [prm_w(N_JOG)-1:0]               premio,
    output logic                                  empate,
    output logic                                  pronto,
    output logic                                  erro
);

    localparam int PTS_W = pts_w(NUM_QTD);
    localparam int PRM_W = prm_w(N_JOG);

    estado_t                       estado_q, estado_d;
    logic [NUM_QTD-1:0][NUM_W-1:0] sorteio_q, sorteio_d, ticket_q, ticket_d;
    logic [PTS_W-1:0]              sorteio_cnt_q, sorteio_cnt_d, ticket_cnt_q, ticket_cnt_d;
    logic [N_JOG-1:0][PTS_W-1:0]   hits_q, hits_d;
    logic [PRM_W-1:0]              jogador_q, jogador_d, premio_q, premio_d;
    logic                          empate_q, empate_d, pronto_q, pronto_d, erro_q, erro_d;

    logic [NUM_QTD-1:0] sorteio_vld, ticket_vld;
    logic               no_sorteio, no_ticket, ultimo_jogador, ticket_cheio;
    logic [PTS_W-1:0]   max_hits;
    logic [PRM_W-1:0]   max_idx, n_max, premio_calc;
    logic               empate_calc;

    always_comb begin
        for (int i = 0; i < NUM_QTD; i++) begin
            sorteio_vld[i] = PTS_W'(i) < sorteio_cnt_q;
            ticket_vld[i]  = PTS_W'(i) < ticket_cnt_q;
        end
    end

    // One matcher serves draw duplicates and ticket hits; the other catches repeated guesses.
    loteria_comparador #(.NUM_W(NUM_W), .NUM_QTD(NUM_QTD)) u_cmp_sorteio (
        .valor (numero),
        .tabela(sorteio_q),
        .valido(sorteio_vld),
        .hit   (no_sorteio)
    );

    loteria_comparador #(.NUM_W(NUM_W), .NUM_QTD(NUM_QTD)) u_cmp_ticket (
        .valor (numero),
        .tabela(ticket_q),
        .valido(ticket_vld),
        .hit   (no_ticket)
    );

    assign ultimo_jogador = (jogador_q == PRM_W'(N_JOG - 1));
    assign ticket_cheio   = (ticket_cnt_q == PTS_W'(NUM_QTD));

    // Winner search: first strict maximum wins, any repeat of that maximum is a tie.
    always_comb begin
        max_hits    = '0;
        max_idx     = '0;
        n_max       = '0;
        premio_calc = '0;
        empate_calc = 1'b0;
        for (int j = 0; j < N_JOG; j++) begin
            if (hits_q[j] > max_hits) begin
                max_hits = hits_q[j];
                max_idx  = PRM_W'(j + 1);
            end
        end
        for (int j = 0; j < N_JOG; j++) begin
            if (hits_q[j] == max_hits) n_max = n_max + PRM_W'(1);
        end
        if (max_hits >= PTS_W'(MIN_ACERTOS)) begin
            if (n_max == PRM_W'(1)) premio_calc = max_idx;
            else                    empate_calc = 1'b1;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            SORTEIO:   if (insere && !no_sorteio && (sorteio_cnt_q == PTS_W'(NUM_QTD - 1)))
                           estado_d = APOSTA;
            APOSTA:    if (fim_jogo || (fim && ultimo_jogador)) estado_d = RESULTADO;
            RESULTADO: if (fim) estado_d = SORTEIO;
            default:   estado_d = SORTEIO;
        endcase
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        sorteio_d     = sorteio_q;
        sorteio_cnt_d = sorteio_cnt_q;
        ticket_d      = ticket_q;
        ticket_cnt_d  = ticket_cnt_q;
        hits_d        = hits_q;
        jogador_d     = jogador_q;
        premio_d      = premio_q;
        empate_d      = empate_q;
        erro_d        = 1'b0;
        pronto_d      = (estado_d == RESULTADO) && (estado_q != RESULTADO);

        case (estado_q)
            SORTEIO: begin
                if (insere) begin
                    if (no_sorteio) begin
                        erro_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_QTD; i++)
                            if (sorteio_cnt_q == PTS_W'(i)) sorteio_d[i] = numero;
                        sorteio_cnt_d = sorteio_cnt_q + PTS_W'(1);
                    end
                end
            end
            APOSTA: begin
                if (insere) begin
                    if (ticket_cheio || no_ticket) begin
                        erro_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_QTD; i++)
                            if (ticket_cnt_q == PTS_W'(i)) ticket_d[i] = numero;
                        ticket_cnt_d = ticket_cnt_q + PTS_W'(1);
                        for (int j = 0; j < N_JOG; j++)
                            if (no_sorteio && (jogador_q == PRM_W'(j)) &&
                                (hits_q[j] != PTS_W'(NUM_QTD)))
                                hits_d[j] = hits_q[j] + PTS_W'(1);
                    end
                end
                // The insert above still lands on the closing ticket before it is cleared.
                if (!fim_jogo && fim && !ultimo_jogador) begin
                    jogador_d    = jogador_q + PRM_W'(1);
                    ticket_d     = '0;
                    ticket_cnt_d = '0;
                end
            end
            RESULTADO: begin
                if (pronto_q) begin
                    premio_d = premio_calc;
                    empate_d = empate_calc;
                end
                if (fim) begin
                    sorteio_d     = '0;
                    sorteio_cnt_d = '0;
                    ticket_d      = '0;
                    ticket_cnt_d  = '0;
                    hits_d        = '0;
                    jogador_d     = '0;
                    premio_d      = '0;
                    empate_d      = 1'b0;
                end else if (insere) begin
                    erro_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the draw and ticket arrays are reset too, so an aborted game leaves no stale entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q      <= SORTEIO;
            sorteio_q     <= '0;
            sorteio_cnt_q <= '0;
            ticket_q      <= '0;
            ticket_cnt_q  <= '0;
            hits_q        <= '0;
            jogador_q     <= '0;
            premio_q      <= '0;
            empate_q      <= 1'b0;
            pronto_q      <= 1'b0;
            erro_q        <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            sorteio_q     <= sorteio_d;
            sorteio_cnt_q <= sorteio_cnt_d;
            ticket_q      <= ticket_d;
            ticket_cnt_q  <= ticket_cnt_d;
            hits_q        <= hits_d;
            jogador_q     <= jogador_d;
            premio_q      <= premio_d;
            empate_q      <= empate_d;
            pronto_q      <= pronto_d;
            erro_q        <= erro_d;
        end
    end

    always_comb begin
        estado  = estado_q;
        jogador = jogador_q;
        pontos  = hits_q;
        premio  = premio_q;
        empate  = empate_q;
        pronto  = pronto_q;
        erro    = erro_q;
    end

endmodule

// File: tb/tb_loteria_multi.sv
// Directed bench for loteria_multi: scenario tasks walk step tables of
// inputs and hand-computed output snapshots.
module tb_loteria_multi;

    logic       clock, reset, insere, fim, fim_jogo;
    logic [3:0] numero;
    logic [1:0] estado, jogador, premio;
    logic [5:0] pontos;
    logic       empate, pronto, erro;

    int passed = 0;
    int total  = 0;

    // Snapshot layout: {estado, jogador, pontos1, pontos0, premio, empate, pronto, erro}.
    localparam logic [14:0] ALL = 15'h7FFF;
    localparam logic [14:0] MP  = 15'h7FE3;   // premio/empate not yet settled on the pronto cycle
    localparam logic [14:0] Z   = 15'h0000;

    typedef struct {
        logic [3:0]  num;
        logic        ins, f, fj;
        logic [14:0] exp, msk;
    } step_t;

    step_t steps[$];

    loteria_multi dut (
        .clock   (clock),
        .reset   (reset),
        .numero  (numero),
        .insere  (insere),
        .fim     (fim),
        .fim_jogo(fim_jogo),
        .estado  (estado),
        .jogador (jogador),
        .pontos  (pontos),
        .premio  (premio),
        .empate  (empate),
        .pronto  (pronto),
        .erro    (erro)
    );

    always #5 clock = ~clock;

    function automatic logic [14:0] snap();
        return {estado, jogador, pontos, premio, empate, pronto, erro};
    endfunction

    function automatic logic [14:0] ev(input logic [1:0] e, input logic [1:0] j,
                                       input logic [2:0] p0, input logic [2:0] p1,
                                       input logic [1:0] pr, input logic em,
                                       input logic pn, input logic er);
        return {e, j, p1, p0, pr, em, pn, er};
    endfunction

    task automatic add(input logic [3:0] num, input logic ins, input logic f,
                       input logic fj, input logic [14:0] exp,
                       input logic [14:0] msk = ALL);
        step_t s;
        s.num = num; s.ins = ins; s.f = f; s.fj = fj; s.exp = exp; s.msk = msk;
        steps.push_back(s);
    endtask

    task automatic add_ins(input logic [3:0] num, input logic [14:0] exp);
        add(num, 1'b1, 1'b0, 1'b0, exp);
    endtask

    task automatic add_draw();
        add_ins(4'd5, Z);
        add_ins(4'd3, Z);
        add_ins(4'd8, Z);
        add_ins(4'd2, Z);
        add_ins(4'd0, ev(1, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic drive(input step_t s);
        numero = s.num; insere = s.ins; fim = s.f; fim_jogo = s.fj;
        @(posedge clock);
        #1;
        numero = '0; insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (snap() !== Z) $display("FAIL reset_initial: got %h expected %h", snap(), Z);
        else passed++;
        reset = 1'b1;
        @(posedge clock);
        #1;
        steps.delete();
        add_draw();
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL reset_pre[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 reset = 1'b0;
        #1;
        total++;
        if (snap() !== Z) $display("FAIL reset_async: got %h expected %h", snap(), Z);
        else passed++;
        reset = 1'b1;
        @(posedge clock);
        #1;
        steps.delete();
        add_draw();
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL reset_post[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        steps.delete();
        add(4'd0, 1'b0, 1'b1, 1'b0, Z);
        add(4'd0, 1'b0, 1'b0, 1'b1, Z);
        add_draw();
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add_ins(4'd8, ev(1, 0, 3, 0, 0, 0, 0, 0));
        add_ins(4'd1, ev(1, 0, 3, 0, 0, 0, 0, 0));
        add_ins(4'd9, ev(1, 0, 3, 0, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(1, 1, 3, 0, 0, 0, 0, 0));
        add_ins(4'd5, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add_ins(4'd7, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add_ins(4'd6, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add_ins(4'd4, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add_ins(4'd1, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(2, 1, 3, 1, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 3, 1, 1, 0, 0, 0));
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 3, 1, 1, 0, 0, 0));
        add_ins(4'd7, ev(2, 1, 3, 1, 1, 0, 0, 1));
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 3, 1, 1, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, Z);
        add(4'd0, 1'b0, 1'b0, 1'b0, Z);
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL basic[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    task automatic test_duplicados();
        do_reset();
        steps.delete();
        add_ins(4'd5, Z);
        add_ins(4'd5, ev(0, 0, 0, 0, 0, 0, 0, 1));
        add(4'd0, 1'b0, 1'b0, 1'b0, Z);
        add_ins(4'd3, Z);
        add_ins(4'd8, Z);
        add_ins(4'd2, Z);
        add_ins(4'd0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 1));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add_ins(4'd8, ev(1, 0, 3, 0, 0, 0, 0, 0));
        add_ins(4'd2, ev(1, 0, 4, 0, 0, 0, 0, 0));
        add_ins(4'd0, ev(1, 0, 5, 0, 0, 0, 0, 0));
        add_ins(4'd7, ev(1, 0, 5, 0, 0, 0, 0, 1));
        add(4'd0, 1'b0, 1'b0, 1'b1, ev(2, 0, 5, 0, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 0, 5, 0, 1, 0, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL duplicados[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    task automatic test_empate();
        do_reset();
        steps.delete();
        add_draw();
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add_ins(4'd8, ev(1, 0, 3, 0, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(1, 1, 3, 0, 0, 0, 0, 0));
        add_ins(4'd8, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add_ins(4'd2, ev(1, 1, 3, 2, 0, 0, 0, 0));
        add_ins(4'd0, ev(1, 1, 3, 3, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(2, 1, 3, 3, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 3, 3, 0, 1, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, Z);
        add_draw();
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(1, 1, 2, 0, 0, 0, 0, 0));
        add_ins(4'd2, ev(1, 1, 2, 1, 0, 0, 0, 0));
        add_ins(4'd0, ev(1, 1, 2, 2, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(2, 1, 2, 2, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 2, 2, 0, 0, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL empate[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    task automatic test_fim_jogo();
        do_reset();
        steps.delete();
        add_draw();
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add(4'd8, 1'b1, 1'b0, 1'b1, ev(2, 0, 3, 0, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 0, 3, 0, 1, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, Z);
        add(4'd0, 1'b0, 1'b0, 1'b0, Z);
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL fim_jogo[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    task automatic test_insere_fim();
        do_reset();
        steps.delete();
        add_draw();
        add_ins(4'd1, ev(1, 0, 0, 0, 0, 0, 0, 0));
        add_ins(4'd5, ev(1, 0, 1, 0, 0, 0, 0, 0));
        add_ins(4'd3, ev(1, 0, 2, 0, 0, 0, 0, 0));
        add(4'd8, 1'b1, 1'b1, 1'b0, ev(1, 1, 3, 0, 0, 0, 0, 0));
        add_ins(4'd5, ev(1, 1, 3, 1, 0, 0, 0, 0));
        add(4'd0, 1'b0, 1'b1, 1'b0, ev(2, 1, 3, 1, 0, 0, 1, 0), MP);
        add(4'd0, 1'b0, 1'b0, 1'b0, ev(2, 1, 3, 1, 1, 0, 0, 0));
        foreach (steps[i]) begin
            drive(steps[i]);
            total++;
            if (((snap() ^ steps[i].exp) & steps[i].msk) !== Z)
                $display("FAIL insere_fim[%0d]: got %h expected %h", i, snap(), steps[i].exp);
            else passed++;
        end
    endtask

    initial begin
        clock    = 1'b0;
        reset    = 1'b0;
        numero   = '0;
        insere   = 1'b0;
        fim      = 1'b0;
        fim_jogo = 1'b0;
        test_reset();
        test_basic();
        test_duplicados();
        test_empate();
        test_fim_jogo();
        test_insere_fim();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/loteria_multi.md
Name: loteria_multi

Overview:
- Parametrised successor to the two-player lottery block. Loads a drawn set of NUM_QTD distinct numbers, then collects one ticket of NUM_QTD guesses per player for N_JOG players.
- Counts hits per player and declares the winner (premio) when the game ends.
- Sits behind the keypad/switch front-end and in front of the score display driver.

Parameters:
- NUM_W, 4, width of each number.
- NUM_QTD, 5, numbers per draw and per ticket.
- N_JOG, 2, number of players.
- MIN_ACERTOS, 3, minimum hits required to win a prize.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- numero  in  NUM_W  number presented with insere.
- insere  in  1  accept numero this cycle (one number per clock while high).
- fim  in  1  close current ticket / restart from RESULTADO.
- fim_jogo  in  1  end game immediately.
- estado  out  2  0=SORTEIO, 1=APOSTA, 2=RESULTADO.
- jogador  out  PRM_W  index of the player currently betting.
- pontos  out  N_JOG*PTS_W  hit counts, player 0 in the LSBs.
- premio  out  PRM_W  0=no winner, i+1=player i wins.
- empate  out  1  tie for best score at or above MIN_ACERTOS.
- pronto  out  1  one-cycle pulse on entry to RESULTADO.
- erro  out  1  one-cycle pulse for a rejected insert.
- Widths: PTS_W=$clog2(NUM_QTD+1); PRM_W=$clog2(N_JOG+1).

Behaviour:
- Reset (reset=0, asynchronous): estado=SORTEIO; all counters, draw registers, ticket registers, pontos, premio, empate, pronto, erro and jogador=0.
- SORTEIO:
  - insere stores numero if it is not already drawn; the draw count increments.
  - A duplicate is not stored; erro=1 for the next cycle.
  - When the NUM_QTD-th number is stored, go to APOSTA on the next clock, jogador=0.
  - fim and fim_jogo are ignored.
- APOSTA:
  - insere with a guess not already on this ticket: store it. If it matches any drawn number, hits[jogador]++ (registered, visible in pontos the next cycle).
  - Duplicate guess, or insere after NUM_QTD guesses: not stored, erro pulse.
  - fim: close the ticket. If jogador<N_JOG-1, then jogador++ and the ticket is cleared. Otherwise go to RESULTADO. A ticket may be closed with fewer than NUM_QTD guesses.
  - fim_jogo: go to RESULTADO immediately. Unplayed players keep 0.
- Same-cycle events:
  - insere+fim: the number is processed first and counts toward the closing ticket.
  - fim_jogo has priority over fim; a concurrent insere is still processed.
- RESULTADO (entered one clock after the triggering event):
  - premio/empate computed combinationally from the registered hits and registered on entry; pronto pulses on that cycle.
  - Max hits >= MIN_ACERTOS and unique: premio=index+1, empate=0.
  - Max tied: premio=0, empate=1.
  - Max < MIN_ACERTOS: premio=0, empate=0.
  - Outputs hold until fim; fim returns to SORTEIO with all state cleared (same values as reset). insere there gives an erro pulse.
- Hit counters cannot exceed NUM_QTD by construction. The hits counter saturates as a safety measure.
- Mid-operation reset aborts any state instantly; no partial result is retained.

Decomposition:
- loteria_pkg holds:
  - the estado enum (SORTEIO, APOSTA, RESULTADO);
  - the width helper functions for PTS_W and PRM_W.
- One sub-module, loteria_comparador: combinational match of a NUM_W value against a NUM_QTD-entry register array with a valid mask. Returns hit=1 if any valid entry is equal.
- Instantiated twice: once against the drawn set (draw duplicates and hits), once against the current ticket (guess duplicates).

Test Plan:
- Reset at any point: all outputs 0, estado=0, within the same cycle reset falls, without waiting for a clock edge.
- Draw 5,3,8,2,0 → estado=1 after the 5th. P0 guesses 5,3,8,1,9 then fim; P1 guesses 5,7,6,4,1 then fim → pontos={1,3}, premio=1, empate=0, single-cycle pronto.
- Draw 5,5 → second insert gives erro=1 for one cycle, draw count stays 1, estado stays 0. Same check for a duplicate guess on a ticket.
- Both players hit 3 → premio=0, empate=1. Both hit 2 → premio=0, empate=0.
- P0 hits 2, then fim_jogo held with insere=8 (a drawn number) → pontos0=3, pontos1=0, premio=1. Then fim → estado=0 with all outputs cleared.
- insere and fim in the same cycle with the 4th guess matching → that hit is counted for the closing player, then jogador advances.
